// File: rtl/bip_control_seq.sv
// bip_control_seq: FETCH/EXEC control unit for the BIP accumulator processor; define BIP_CONTROL_BRANCH_EN to enable BEQZ/BNEZ/JMP
module bip_control_seq #(
  parameter int NB_DATA    = 16,
  parameter int NB_OPCODE  = 5,
  parameter int NB_OPERAND = 11,
  parameter int NB_PC      = 11,
  parameter int NB_SEL_A   = 2,
  parameter int NB_COUNT   = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [NB_DATA-1:0]    i_instruction,
  input  logic                  i_acc_zero,
  output logic [NB_PC-1:0]      o_pc,
  output logic [NB_OPERAND-1:0] o_operand,
  output logic [NB_SEL_A-1:0]   o_sel_a,
  output logic                  o_sel_b,
  output logic                  o_op_code,
  output logic                  o_wr_acc,
  output logic                  o_wr_ram,
  output logic                  o_rd_ram,
  output logic                  o_halted,
  output logic [NB_COUNT-1:0]   o_instr_count
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);
  localparam logic [NB_OPCODE-1:0] OP_BEQZ = NB_OPCODE'(8);
  localparam logic [NB_OPCODE-1:0] OP_BNEZ = NB_OPCODE'(9);
  localparam logic [NB_OPCODE-1:0] OP_JMP  = NB_OPCODE'(10);
`ifdef BIP_CONTROL_BRANCH_EN
  localparam bit BRANCH_EN = 1'b1;
`else
  localparam bit BRANCH_EN = 1'b0;
`endif
  state_t state;
  logic [NB_OPCODE-1:0] opcode;
  logic exec_now, is_branch, halt_op, taken;
  logic [6:0] ctrl;
  assign opcode    = i_instruction[NB_DATA-1 -: NB_OPCODE];
  assign o_operand = i_instruction[NB_OPERAND-1:0];
  assign exec_now  = (state == EXEC) && i_valid;
  // Decode: branch classification and strobe pattern {sel_a, sel_b, op_code, wr_acc, wr_ram, rd_ram}
  always_comb begin
    is_branch = BRANCH_EN && (opcode == OP_BEQZ || opcode == OP_BNEZ || opcode == OP_JMP);
    halt_op   = !is_branch && (opcode == OP_HLT || opcode > OP_SUBI);
    taken     = is_branch && (opcode == OP_JMP || ((opcode == OP_BEQZ) == i_acc_zero));
    case (opcode)
      OP_STO:  ctrl = 7'b00_0_0_0_1_0;
      OP_LD:   ctrl = 7'b00_0_0_1_0_1;
      OP_LDI:  ctrl = 7'b01_0_0_1_0_0;
      OP_ADD:  ctrl = 7'b10_0_1_1_0_1;
      OP_ADDI: ctrl = 7'b10_1_1_1_0_0;
      OP_SUB:  ctrl = 7'b10_0_0_1_0_1;
      OP_SUBI: ctrl = 7'b10_1_0_1_0_0;
      default: ctrl = 7'b0;
    endcase
    {o_sel_a, o_sel_b, o_op_code, o_wr_acc, o_wr_ram, o_rd_ram} =
      exec_now ? {NB_SEL_A'(ctrl[6:5]), ctrl[4:0]} : '0;
  end
  // FSM with PC, retired-instruction counter and sticky halt flag
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= FETCH;
      o_pc          <= '0;
      o_instr_count <= '0;
      o_halted      <= 1'b0;
    end else begin
      case (state)
        FETCH: if (i_valid) state <= EXEC;
        EXEC: if (i_valid) begin
          if (halt_op) begin
            state    <= HALT;
            o_halted <= 1'b1;
          end else begin
            state         <= FETCH;
            o_pc          <= taken ? NB_PC'(i_instruction[NB_OPERAND-1:0]) : o_pc + 1'b1;
            o_instr_count <= &o_instr_count ? o_instr_count : o_instr_count + 1'b1;
          end
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: doc/bip_control_seq.md
# bip_control_seq

Multi-cycle, parametrised control unit for the BIP accumulator processor. It replaces the single-cycle combinational decoder with a FETCH/EXEC state machine. It adds conditional and unconditional branches, a sticky halt state and an executed-instruction counter. It sits between the instruction memory (synchronous read, 1-cycle latency) and the datapath (accumulator, ALU, data RAM).

## Interface
Parameters:
- NB_DATA, 16: instruction width
- NB_OPCODE, 5: opcode field width, taken from instruction[NB_DATA-1 -: NB_OPCODE]
- NB_OPERAND, 11: operand field width, taken from instruction[NB_OPERAND-1:0]
- NB_PC, 11: program counter width
- NB_SEL_A, 2: accumulator-input mux select width
- NB_COUNT, 16: executed-instruction counter width

Ports:
- i_clock  in  1  sole clock; all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  step enable; low freezes the FSM, PC and counter
- i_instruction  in  NB_DATA  instruction memory read data for the address presented in the previous cycle
- i_acc_zero  in  1  accumulator == 0
- o_pc  out  NB_PC  instruction memory address
- o_operand  out  NB_OPERAND  operand field of i_instruction (data RAM address / immediate)
- o_sel_a  out  NB_SEL_A  accumulator source: 00 RAM, 01 immediate, 10 ALU
- o_sel_b  out  1  ALU B operand: 0 RAM, 1 immediate
- o_op_code  out  1  ALU op: 1 add, 0 subtract
- o_wr_acc  out  1  accumulator write strobe
- o_wr_ram  out  1  data RAM write strobe
- o_rd_ram  out  1  data RAM read strobe
- o_halted  out  1  high once HALT state entered
- o_instr_count  out  NB_COUNT  retired-instruction count, saturating

## Operation
- States: FETCH, EXEC, HALT.
- FETCH, i_valid=1: go to EXEC.
- FETCH, i_valid=0: hold.
- EXEC, i_valid=1: decode i_instruction and assert strobes for this cycle only. Update the PC and the counter at the clock edge. Next state is FETCH, or HALT for HLT/illegal opcodes.
- EXEC, i_valid=0: all strobes 0; hold state, PC and count.
- HALT: all strobes 0, o_halted=1. Only reset exits.
- Opcode decode (sel_a, sel_b, op_code, wr_acc, wr_ram, rd_ram):
  - 0 HLT: all 0
  - 1 STO: 00,0,0,0,1,0
  - 2 LD: 00,0,0,1,0,1
  - 3 LDI: 01,0,0,1,0,0
  - 4 ADD: 10,0,1,1,0,1
  - 5 ADDI: 10,1,1,1,0,0
  - 6 SUB: 10,0,0,1,0,1
  - 7 SUBI: 10,1,0,1,0,0
  - 8 BEQZ, 9 BNEZ, 10 JMP: all strobes 0
  - 11..2^NB_OPCODE-1: illegal, treated as HLT
- PC next value:
  - BEQZ with i_acc_zero=1, BNEZ with i_acc_zero=0, JMP: operand zero-extended or truncated to NB_PC.
  - All other executed instructions: pc+1, wrapping modulo 2^NB_PC.
  - HLT/illegal: PC unchanged.
- Counter: increments on each executed non-halting instruction (branches included). Saturates at all-ones.
- Strobes are combinational from state, i_valid and opcode. They are forced to 0 outside EXEC.

## Timing
- Reset values: state FETCH, o_pc=0, o_instr_count=0, o_halted=0, all strobes 0.
- Reset takes effect asynchronously, including mid-EXEC. Strobes drop immediately.
- Each instruction takes 2 cycles with i_valid held high. The PC changes at the end of EXEC.
- i_acc_zero is sampled in EXEC and reflects the previous instruction's accumulator write.
- o_halted rises the cycle after the halting EXEC.

## Configuration
- BIP_CONTROL_BRANCH_EN defined: opcodes 8, 9 and 10 execute as described above.
- BIP_CONTROL_BRANCH_EN undefined: opcodes 8, 9 and 10 are illegal and halt the unit. The i_acc_zero input is retained but unused.

## Test plan
- Reset: assert i_reset mid-EXEC of ADDI. Expect strobes 0 immediately, o_pc=0, count=0, state FETCH after release.
- Program LDI 5, ADDI 3, STO 7, HLT with i_valid=1: expect strobe patterns per the decode table on cycles 1, 3, 5; o_operand=7 with wr_ram=1; o_halted=1 at cycle 8; count=3; PC frozen at 3.
- BEQZ 20 with i_acc_zero=1: next o_pc=20. With i_acc_zero=0: o_pc=pc+1. BNEZ gives the inverse. JMP 0x7FF: o_pc=0x7FF.
- PC wrap: JMP 2047, then ADDI. Expect o_pc=0.
- i_valid deasserted during FETCH and during EXEC for 3 cycles: expect no strobes, PC and count unchanged, resume cleanly.
- Build without BIP_CONTROL_BRANCH_EN: JMP 4 halts, PC unchanged, count unchanged. Opcode 31 halts in both builds.
